scaler_rd_arb: RTL and testbench



---
 rtl/scaler_rd_arb_if.sv | 27 ++
 rtl/scaler_rd_arb.sv | 149 ++++++++++++++
 tb/tb_scaler_rd_arb.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scaler_rd_arb_if.sv
// Bundles the requester handshake and scaler ROM port of scaler_rd_arb.
// The slave modport is the arbiter's view; the master modport is the requesters' and ROM's view.
interface scaler_rd_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;
  logic                      mem_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_dout;

  modport master (
    output req, req_addr, mem_dout,
    input  gnt, rsp_valid, rsp_data, busy, mem_en, mem_addr
  );

  modport slave (
    input  req, req_addr, mem_dout,
    output gnt, rsp_valid, rsp_data, busy, mem_en, mem_addr
  );
endinterface

// File: rtl/scaler_rd_arb.sv
// Round-robin arbiter and read sequencer sharing one scaler ROM between NUM_REQ engines.
// Define SCALER_RD_ARB_LAST_HIT_EN to serve a repeat of the last-read address without a ROM access.
module scaler_rd_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 32
) (
  input logic            clk,
  input logic            rst_n,
  scaler_rd_arb_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3
`ifdef SCALER_RD_ARB_LAST_HIT_EN
    ,HIT  = 3'd4
`endif
  } state_t;

  state_t              state, state_d, win_state;
  logic [IDX_W-1:0]    last, last_d, w, w_d;
  logic [NUM_REQ-1:0]  gnt, gnt_d, rsp_valid, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data, rsp_data_d;
  logic                busy, busy_d, mem_en, mem_en_d;
  logic [ADDR_W-1:0]   mem_addr, mem_addr_d;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic                arb_en, win_found, hit;
  logic [IDX_W-1:0]    win_idx, cand;
  logic [ADDR_W-1:0]   win_addr;

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_addr
    assign addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
  end

  // Round-robin search from last+1; iterating downward lets the nearest candidate win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % int'(NUM_REQ));
      if (bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_addr = addr_arr[win_idx];
  assign arb_en   = (state == IDLE) || (state == RESP);

`ifdef SCALER_RD_ARB_LAST_HIT_EN
  logic [ADDR_W-1:0] last_addr;
  logic              last_valid;

  assign hit       = last_valid && (win_addr == last_addr);
  assign win_state = hit ? HIT : ISSUE;

  // ROM contents are constant, so the last captured word stays reusable until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr  <= '0;
      last_valid <= 1'b0;
    end else if (state == WAIT) begin
      last_addr  <= mem_addr;
      last_valid <= 1'b1;
    end
  end
`else
  assign hit       = 1'b0;
  assign win_state = ISSUE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, RESP: state_d = win_found ? win_state : IDLE;
      ISSUE:      state_d = WAIT;
      WAIT:       state_d = RESP;
`ifdef SCALER_RD_ARB_LAST_HIT_EN
      HIT:        state_d = RESP;
`endif
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    rsp_valid_d = '0;
    mem_en_d    = 1'b0;
    mem_addr_d  = mem_addr;
    rsp_data_d  = rsp_data;
    last_d      = last;
    w_d         = w;
    busy_d      = (state_d != IDLE);
    if (arb_en && win_found) begin
      w_d            = win_idx;
      last_d         = win_idx;
      gnt_d[win_idx] = 1'b1;
      mem_en_d       = !hit;
      mem_addr_d     = win_addr;
    end
    if (state == WAIT) begin
      rsp_data_d     = bus.mem_dout;
      rsp_valid_d[w] = 1'b1;
    end
`ifdef SCALER_RD_ARB_LAST_HIT_EN
    if (state == HIT) rsp_valid_d[w] = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      last      <= IDX_W'(NUM_REQ - 1);
      w         <= '0;
    end else begin
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      busy      <= busy_d;
      mem_en    <= mem_en_d;
      mem_addr  <= mem_addr_d;
      last      <= last_d;
      w         <= w_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.busy      = busy;
  assign bus.mem_en    = mem_en;
  assign bus.mem_addr  = mem_addr;
endmodule

// File: tb/tb_scaler_rd_arb.sv
// Scoreboard bench for scaler_rd_arb: a transaction-level round-robin model predicts grants and responses.
// Honours SCALER_RD_ARB_LAST_HIT_EN the same way as the design.
module tb_scaler_rd_arb;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DATA_W  = 32;

  typedef struct {
    int               idx;
    logic [ADDR_W-1:0] addr;
    logic             mem;
    longint           cyc;
  } gexp_t;

  typedef struct {
    int               idx;
    logic [DATA_W-1:0] data;
    longint           cyc;
  } rexp_t;

  logic clk = 1'b0;
  logic rst_n;
  scaler_rd_arb_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  scaler_rd_arb #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM: word = 0xC0DE_0000 + addr, one-cycle latency, enable-gated
  always @(posedge clk) if (bus.mem_en) bus.mem_dout <= 32'hC0DE_0000 + DATA_W'(bus.mem_addr);

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  gexp_t  gq[$];
  rexp_t  rq[$];

  // Model state (written only by the stimulus process)
  longint            next_arb, busy_from, busy_until;
  int                ptr;
  logic              m_last_valid;
  logic [ADDR_W-1:0] m_last_addr;

  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void flag(string name, logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s @cyc %0d: got %0h want none", name, cyc, act);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(int idx);
    logic [NUM_REQ-1:0] v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [NUM_REQ*ADDR_W-1:0] pack(int a0, int a1, int a2, int a3);
    return {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
  endfunction

  function automatic void model_reset();
    next_arb     = 0;
    busy_from    = 0;
    busy_until   = -1;
    ptr          = NUM_REQ - 1;
    m_last_valid = 1'b0;
    m_last_addr  = '0;
    gq.delete();
    rq.delete();
  endfunction

  // One arbitration opportunity per call; decides the winner from this cycle's request levels.
  function automatic void model_eval();
    int found = 0;
    int win = 0;
    int lat;
    logic h;
    logic [ADDR_W-1:0] a;
    if (cyc < next_arb) return;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      int i = (ptr + k) % NUM_REQ;
      if (found == 0 && bus.req[i]) begin
        found = 1;
        win   = i;
      end
    end
    if (found == 0) return;
    a = bus.req_addr[win*ADDR_W +: ADDR_W];
`ifdef SCALER_RD_ARB_LAST_HIT_EN
    h = m_last_valid && (a == m_last_addr);
`else
    h = 1'b0;
`endif
    lat = h ? 2 : 3;
    ptr = win;
    gq.push_back('{win, a, !h, cyc + 1});
    rq.push_back('{win, 32'hC0DE_0000 + DATA_W'(a), cyc + lat});
    if (cyc > busy_until) busy_from = cyc + 1;
    busy_until = cyc + lat;
    next_arb   = cyc + lat;
    if (!h) begin
      m_last_valid = 1'b1;
      m_last_addr  = a;
    end
  endfunction

  task automatic drive_cycle(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*ADDR_W-1:0] a);
    @(posedge clk);
    #1;
    bus.req      = r;
    bus.req_addr = a;
    model_eval();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_gnt"},       64'(bus.gnt),       64'(0));
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, "_rsp_data"},  64'(bus.rsp_data),  64'(0));
    check({tag, "_busy"},      64'(bus.busy),      64'(0));
    check({tag, "_mem_en"},    64'(bus.mem_en),    64'(0));
    check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'(0));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or a response
  logic [DATA_W-1:0] hold = '0;
  always @(negedge clk) begin : monitor
    gexp_t ge;
    rexp_t re;
    if (!rst_n) begin
      hold = '0;
    end else begin
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        ge = gq.pop_front();
        flag("gnt_missing", 64'(ge.idx));
      end
      if (bus.gnt != '0) begin
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
          ge = gq.pop_front();
          check("gnt", 64'(bus.gnt), 64'(onehot(ge.idx)));
          check("mem_en", 64'(bus.mem_en), 64'(ge.mem));
          if (ge.mem) check("mem_addr", 64'(bus.mem_addr), 64'(ge.addr));
        end else begin
          flag("gnt_unexpected", 64'(bus.gnt));
        end
      end else begin
        check("mem_en_without_gnt", 64'(bus.mem_en), 64'(0));
      end

      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        re = rq.pop_front();
        flag("rsp_missing", 64'(re.idx));
      end
      if (bus.rsp_valid != '0) begin
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
          re = rq.pop_front();
          check("rsp_valid", 64'(bus.rsp_valid), 64'(onehot(re.idx)));
          hold = re.data;
        end else begin
          flag("rsp_unexpected", 64'(bus.rsp_valid));
        end
      end
      check("rsp_data", 64'(bus.rsp_data), 64'(hold));
      check("busy", 64'(bus.busy), 64'((cyc >= busy_from) && (cyc <= busy_until)));
    end
  end

  logic [NUM_REQ-1:0]        rr;
  logic [NUM_REQ*ADDR_W-1:0] ra;

  initial begin
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    #2;
    rst_n = 1'b1;

    // Single request from requester 2, address 5
    drive_cycle(4'b0100, pack(0, 0, 5, 0));
    repeat (6) drive_cycle('0, pack(0, 0, 5, 0));

    // All four requesters held: round-robin grant order
    repeat (14) drive_cycle(4'b1111, pack(1, 2, 3, 4));
    repeat (5) drive_cycle('0, pack(1, 2, 3, 4));

    // Requester 1 pulses while requester 0 is being served
    drive_cycle(4'b0001, pack(2, 9, 0, 0));
    drive_cycle(4'b0010, pack(2, 9, 0, 0));
    repeat (6) drive_cycle('0, pack(2, 9, 0, 0));

    // Reset while the read is in WAIT
    drive_cycle(4'b0001, pack(3, 0, 0, 0));
    drive_cycle('0, pack(3, 0, 0, 0));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    drive_cycle(4'b1111, pack(1, 2, 3, 4));
    repeat (5) drive_cycle('0, pack(1, 2, 3, 4));

    // Back-to-back reads of address 7 by one requester
    repeat (4) drive_cycle(4'b0001, pack(7, 0, 0, 0));
    repeat (6) drive_cycle('0, pack(7, 0, 0, 0));

    // Randomized traffic; addresses change only while a requester is idle
    rr = '0;
    ra = '0;
    repeat (400) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (rr[i]) begin
          if ($urandom_range(0, 3) == 0) rr[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          rr[i] = 1'b1;
          ra[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 5));
        end
      end
      drive_cycle(rr, ra);
    end
    repeat (8) drive_cycle('0, ra);

    check("gnt_queue_drained", 64'(gq.size()), 64'(0));
    check("rsp_queue_drained", 64'(rq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
